regslv_fwd_slice: RTL
=====================

REGSLV_FWD_SLICE -- requirements
Module: regslv_fwd_slice

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 64, reg_native_if address width.
- DATA_WIDTH, 32, reg_native_if data width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (1..65535).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- fsm_clk  in  1  single clock; all logic on its rising edge.
- fsm_rst  in  1  reset; synchronous, active-high.
- global_sync_reset_in  in  1  synchronous soft reset, active-high.
- req_vld  in  1  upstream request pulse.
- wr_en  in  1  upstream write qualifier.
- rd_en  in  1  upstream read qualifier.
- addr  in  ADDR_WIDTH  upstream address.
- wr_data  in  DATA_WIDTH  upstream write data.
- ack_vld  out  1  upstream response pulse.
- rd_data  out  DATA_WIDTH  upstream read data.
- ds_req_vld  out  1  downstream request pulse.
- ds_wr_en, ds_rd_en  out  1 each  downstream qualifiers.
- ds_addr  out  ADDR_WIDTH  downstream address.
- ds_wr_data  out  DATA_WIDTH  downstream write data.
- ds_ack_vld  in  1  downstream response pulse.
- ds_rd_data  in  DATA_WIDTH  downstream read data.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.
- drop_err  out  1  one-cycle pulse when a request is dropped.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE: req_vld=1 with exactly one of wr_en/rd_en set SHALL capture addr/wr_data/wr_en/rd_en and go to ISSUE.
REQ-005 IDLE: req_vld=1 with wr_en=rd_en (both 0 or both 1) SHALL return ack_vld next cycle with rd_data=0, pulse drop_err, and issue nothing downstream.
REQ-006 ISSUE: ds_req_vld SHALL be high exactly one cycle, with the captured qualifiers, address and data; the state SHALL then advance to WAIT.
REQ-007 ds_ack_vld SHALL be accepted in ISSUE or WAIT; it SHALL latch ds_rd_data (reads) or 0 (writes) and go to RESP.
REQ-008 RESP: ack_vld SHALL be high one cycle with the latched rd_data; the state SHALL then return to IDLE.
REQ-009 Latency: req_vld at cycle T gives ds_req_vld at T+1; ds_ack_vld at T+1+k (k>=0) gives ack_vld at T+2+k.
REQ-010 req_vld in any state other than IDLE SHALL be dropped, pulse drop_err, and leave the pending transaction unaffected.
REQ-011 ds_ack_vld seen in IDLE or RESP (late or spurious) SHALL be ignored.
REQ-012 ds_* outputs SHALL hold their captured values until the next capture; ds_req_vld SHALL be 0 outside ISSUE.
REQ-013 ack_vld SHALL be 0 outside RESP; rd_data SHALL hold its last value between responses.

Reset
REQ-014 fsm_rst=1 at a clock edge SHALL force IDLE, watchdog counter 0, and all outputs and captured registers 0.
REQ-015 global_sync_reset_in=1 SHALL behave identically to fsm_rst; it SHALL abort any pending transaction without asserting ack_vld.
REQ-016 Reset asserted mid-transaction SHALL abort it; a ds_ack_vld arriving after reset release SHALL be ignored per REQ-011.

Configuration
REQ-017 With macro REGSLV_FWD_SLICE_TIMEOUT_EN defined:
- A 16-bit counter SHALL clear on entry to ISSUE and increment every cycle in ISSUE/WAIT.
- When the count reaches TIMEOUT_CYCLES without ds_ack_vld, the block SHALL go to RESP with rd_data=32'hDEAD_BEEF (low DATA_WIDTH bits) and pulse timeout_err together with ack_vld.
- ds_ack_vld in the expiry cycle SHALL win: normal response, no timeout_err.
REQ-018 Without REGSLV_FWD_SLICE_TIMEOUT_EN:
- No counter SHALL be built.
- WAIT SHALL persist until ds_ack_vld.
- timeout_err SHALL be tied to 0.

Verification
REQ-019 Write addr=0x0, wr_data=0xFFFFFFFF, downstream ack 3 cycles after ds_req_vld -> ds_* match inputs, ack_vld 5 cycles after req_vld, rd_data=0.
REQ-020 Read with ds_ack_vld in the same cycle as ds_req_vld, ds_rd_data=0x12345678 -> ack_vld at T+2, rd_data=0x12345678.
REQ-021 Second req_vld while in WAIT -> drop_err pulses once; the first transaction completes with unchanged data.
REQ-022 TIMEOUT_EN, TIMEOUT_CYCLES=4, no downstream ack:
- ack_vld and timeout_err pulse together.
- rd_data=0xDEADBEEF.
- A later ds_ack_vld is ignored.
REQ-023 global_sync_reset_in pulsed during WAIT -> IDLE next cycle, no ack_vld; the next read completes normally.
REQ-024 req_vld with wr_en=rd_en=1 -> no ds_req_vld; ack_vld at T+1 with rd_data=0; drop_err pulses.

Source files
------------

// File: rtl/regslv_fwd_slice.sv
// regslv_fwd_slice: forwards one register request at a time downstream and returns its response upstream.
// Optional watchdog: define REGSLV_FWD_SLICE_TIMEOUT_EN to build the timeout counter.
module regslv_fwd_slice #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rst,
  input  logic                  global_sync_reset_in,
  input  logic                  req_vld,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ds_req_vld,
  output logic                  ds_wr_en,
  output logic                  ds_rd_en,
  output logic [ADDR_WIDTH-1:0] ds_addr,
  output logic [DATA_WIDTH-1:0] ds_wr_data,
  input  logic                  ds_ack_vld,
  input  logic [DATA_WIDTH-1:0] ds_rd_data,
  output logic                  timeout_err,
  output logic                  drop_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t                state_r;
  state_t                state_nx_s;
  logic                  rst_s;
  logic                  capture_s;
  logic                  drop_s;
  logic                  resp_load_s;
  logic                  tmo_take_s;
  logic                  tmo_hit_s;
  logic [DATA_WIDTH-1:0] resp_data_s;
  logic [DATA_WIDTH-1:0] tmo_data_s;

  logic                  ack_vld_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  ds_req_vld_r;
  logic                  ds_wr_en_r;
  logic                  ds_rd_en_r;
  logic [ADDR_WIDTH-1:0] ds_addr_r;
  logic [DATA_WIDTH-1:0] ds_wr_data_r;
  logic                  timeout_err_r;
  logic                  drop_err_r;

  // Both reset sources have identical effect.
  assign rst_s = fsm_rst | global_sync_reset_in;

`ifdef REGSLV_FWD_SLICE_TIMEOUT_EN
  localparam logic [31:0] TMO_PATTERN = 32'hDEAD_BEEF;

  logic [15:0] tmo_cnt_r;

  assign tmo_hit_s  = (tmo_cnt_r == TMO_LIMIT);
  assign tmo_data_s = DATA_WIDTH'(TMO_PATTERN);

  // Watchdog: zero in ISSUE (cleared on capture), counts each ISSUE/WAIT cycle.
  always_ff @(posedge fsm_clk) begin
    if (rst_s) begin
      tmo_cnt_r <= 16'd0;
    end else if (capture_s) begin
      tmo_cnt_r <= 16'd0;
    end else if ((state_r == ISSUE) || (state_r == WAIT)) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  logic unused_tmo_s;

  assign tmo_hit_s    = 1'b0;
  assign tmo_data_s   = {DATA_WIDTH{1'b0}};
  assign unused_tmo_s = ^TMO_LIMIT;
`endif

  // Next-state and per-cycle decisions.
  always_comb begin
    state_nx_s  = state_r;
    capture_s   = 1'b0;
    drop_s      = 1'b0;
    resp_load_s = 1'b0;
    tmo_take_s  = 1'b0;
    resp_data_s = {DATA_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_vld) begin
          if (wr_en ^ rd_en) begin
            capture_s  = 1'b1;
            state_nx_s = ISSUE;
          end else begin
            // Ambiguous qualifiers: answer with zero data, never forward.
            drop_s      = 1'b1;
            resp_load_s = 1'b1;
            state_nx_s  = RESP;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE, WAIT: begin
        drop_s = req_vld;
        if (ds_ack_vld) begin
          resp_load_s = 1'b1;
          resp_data_s = ds_rd_en_r ? ds_rd_data : {DATA_WIDTH{1'b0}};
          state_nx_s  = RESP;
        end else if (tmo_hit_s) begin
          resp_load_s = 1'b1;
          tmo_take_s  = 1'b1;
          resp_data_s = tmo_data_s;
          state_nx_s  = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP: begin
        drop_s     = req_vld;
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, output pulses and captured request/response registers.
  always_ff @(posedge fsm_clk) begin
    if (rst_s) begin
      state_r       <= IDLE;
      ack_vld_r     <= 1'b0;
      rd_data_r     <= {DATA_WIDTH{1'b0}};
      ds_req_vld_r  <= 1'b0;
      ds_wr_en_r    <= 1'b0;
      ds_rd_en_r    <= 1'b0;
      ds_addr_r     <= {ADDR_WIDTH{1'b0}};
      ds_wr_data_r  <= {DATA_WIDTH{1'b0}};
      timeout_err_r <= 1'b0;
      drop_err_r    <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      ack_vld_r     <= (state_nx_s == RESP);
      ds_req_vld_r  <= capture_s;
      timeout_err_r <= tmo_take_s;
      drop_err_r    <= drop_s;
      if (capture_s) begin
        ds_wr_en_r   <= wr_en;
        ds_rd_en_r   <= rd_en;
        ds_addr_r    <= addr;
        ds_wr_data_r <= wr_data;
      end
      if (resp_load_s) begin
        rd_data_r <= resp_data_s;
      end
    end
  end

  assign ack_vld     = ack_vld_r;
  assign rd_data     = rd_data_r;
  assign ds_req_vld  = ds_req_vld_r;
  assign ds_wr_en    = ds_wr_en_r;
  assign ds_rd_en    = ds_rd_en_r;
  assign ds_addr     = ds_addr_r;
  assign ds_wr_data  = ds_wr_data_r;
  assign timeout_err = timeout_err_r;
  assign drop_err    = drop_err_r;

endmodule
